pipe_addsub: RTL and testbench
==============================

# pipe_addsub

Parametrised, pipelined add/subtract unit with valid/ready flow control and four operation modes. It generalises the fixed 4-bit, fixed-latency subtract block to configurable operand width and pipeline depth. It also adds per-transaction mode select and output backpressure. It sits between an upstream operand producer and a downstream consumer in the datapath. Results return in order.

## Interface
- WIDTH, 4, operand width in bits (unsigned operands); ≥ 2
- LATENCY, 3, number of register stages from input accept to result valid; ≥ 1
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- inValid  input  1  operand beat valid
- inReady  output  1  unit can accept a beat this cycle
- modeIn  input  2  operation for this beat: 0 SUB a−b, 1 ADD a+b, 2 RSUB b−a, 3 ABS |a−b|
- aIn  input  WIDTH  operand a, unsigned
- bIn  input  WIDTH  operand b, unsigned
- outValid  output  1  resOut holds a valid result
- outReady  input  1  consumer accepts result this cycle
- resOut  output  WIDTH+1  signed result
- satOut  output  1  result was clamped (present only with PIPE_ADDSUB_SAT_EN)

## Operation
- A beat is accepted on a rising edge where inValid && inReady. The mode is captured with the operands.
- Stage 1 computes the result. Stages 2..LATENCY are pure delay, each stage carrying a valid bit, the result and the sat flag.
- Global pipeline enable: en = !(outValid && !outReady). inReady = en (combinational).
- When en = 0, every stage holds, including resOut and outValid.
- Bubbles are not collapsed: an invalid stage still advances only when en = 1.
- Arithmetic: operands are zero-extended to WIDTH+2 bits and computed exactly, then reduced to WIDTH+1 signed.
  - SUB and RSUB range is −(2^WIDTH−1)..2^WIDTH−1. This always fits.
  - ABS is always ≥ 0 and fits.
  - ADD can exceed 2^WIDTH−1. Reduction of an ADD result depends on configuration.
- The result of an invalid stage is don't-care internally. resOut is only updated when an enabled stage moves data.
- Reset (any cycle, including mid-stream): all stage valids clear, resOut = 0, satOut = 0. In-flight beats are discarded, never emitted.

## Timing
- With no stall, a beat accepted at edge k gives outValid = 1 with its result after edge k+LATENCY.
- Throughput: 1 beat per cycle while outReady = 1.
- A stall of N cycles (outValid && !outReady) delays every in-flight beat by exactly N cycles.
- On the cycle outReady rises, the held result is consumed and the next one appears after that edge.
- Reset values: inReady = 1 on the first cycle after reset is released (outValid = 0), outValid = 0, resOut = 0, satOut = 0.
- While rst = 1, outValid is forced to 0 and no beats are accepted.

## Configuration
- PIPE_ADDSUB_SAT_EN defined: an ADD result > 2^WIDTH−1 clamps to 2^WIDTH−1. The satOut port exists and is 1 for that beat, travelling with the result.
- PIPE_ADDSUB_SAT_EN undefined: an ADD result wraps to two's complement (low WIDTH+1 bits). The satOut port is absent.

## Structure
- Package pipe_addsub_pkg:
  - mode constants MODE_SUB, MODE_ADD, MODE_RSUB, MODE_ABS (2-bit)
  - function for result width (WIDTH+1)
- Sub-module addsub_calc: combinational stage-1 datapath (mode decode, exact compute, wrap or clamp, sat flag).
- The top level holds the parameterised register chain (generate loop), the enable logic and the reset.

## Test plan
- WIDTH=4, LATENCY=3, outReady=1. Back-to-back SUB beats (10,6), (5,8), (3,3) from the cycle after reset release give resOut 4, −3, 0 on three consecutive cycles, the first valid 3 edges after its accept.
- Modes on (5,8): RSUB → 3, ABS → 3, ADD → 13 (no sat), SUB → −3. Results return in issue order.
- ADD (15,15):
  - without the macro → resOut = −2 (30 wrapped to 5 bits)
  - with PIPE_ADDSUB_SAT_EN → resOut = 15, satOut = 1
  - the following ADD (1,2) → 3, satOut = 0
- Backpressure: stream 4 beats, drop outReady for 2 cycles after the first result.
  - resOut is held and inReady = 0 during the stall.
  - All 4 results arrive in order with none lost or duplicated.
- Reset mid-stream: assert rst for 1 cycle with 3 beats in flight.
  - outValid = 0 and resOut = 0 next cycle.
  - No stale result ever appears.
  - A new beat (7,2,SUB) then yields 5 with the normal latency.
- LATENCY=1 and WIDTH=8 build: SUB (0,255) → −255, ADD (255,255) → wraps/clamps per macro, 1-cycle latency.

Source files
------------

// File: rtl/pipe_addsub_pkg.sv
// Shared definitions for pipe_addsub: operation codes and the result-width helper.
package pipe_addsub_pkg;

    localparam logic [1:0] MODE_SUB  = 2'd0;
    localparam logic [1:0] MODE_ADD  = 2'd1;
    localparam logic [1:0] MODE_RSUB = 2'd2;
    localparam logic [1:0] MODE_ABS  = 2'd3;

    function automatic int resultWidth(input int width);
        return width + 1;
    endfunction

endpackage

// File: rtl/pipe_addsub_calc.sv
// Stage-1 combinational datapath: mode decode, exact compute, then wrap or clamp.
// PIPE_ADDSUB_SAT_EN selects clamping of ADD overflow and adds the sat output.
module addsub_calc
    import pipe_addsub_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH:0]   res
`ifdef PIPE_ADDSUB_SAT_EN
    ,
    output logic             sat
`endif
);

    // The clamping build needs one extra bit to see ADD overflow; wrapping does not.
`ifdef PIPE_ADDSUB_SAT_EN
    localparam int CW = WIDTH + 2;
`else
    localparam int CW = WIDTH + 1;
`endif

    logic [CW-1:0] aExt;
    logic [CW-1:0] bExt;
    logic [CW-1:0] exact;

    assign aExt = CW'(a);
    assign bExt = CW'(b);

    always_comb begin
        case (mode)
            MODE_SUB:  exact = aExt - bExt;
            MODE_ADD:  exact = aExt + bExt;
            MODE_RSUB: exact = bExt - aExt;
            default:   exact = (a >= b) ? (aExt - bExt) : (bExt - aExt);
        endcase
    end

`ifdef PIPE_ADDSUB_SAT_EN
    always_comb begin
        sat = (mode == MODE_ADD) && (exact[WIDTH+1:WIDTH] != 2'b00);
        res = sat ? {1'b0, {WIDTH{1'b1}}} : exact[WIDTH:0];
    end
`else
    assign res = exact;
`endif

endmodule

// File: rtl/pipe_addsub.sv
// Pipelined add/subtract unit with valid/ready flow control and a global stall enable.
// PIPE_ADDSUB_SAT_EN enables ADD saturation and the satOut port.
module pipe_addsub
    import pipe_addsub_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int LATENCY = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inValid,
    output logic             inReady,
    input  logic [1:0]       modeIn,
    input  logic [WIDTH-1:0] aIn,
    input  logic [WIDTH-1:0] bIn,
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH:0]   resOut
`ifdef PIPE_ADDSUB_SAT_EN
    ,
    output logic             satOut
`endif
);

    localparam int RW = resultWidth(WIDTH);

    typedef struct packed {
        logic          valid;
        logic [RW-1:0] res;
`ifdef PIPE_ADDSUB_SAT_EN
        logic          sat;
`endif
    } stage_t;

    logic             en;
    logic             inRegValid;
    logic [1:0]       inRegMode;
    logic [WIDTH-1:0] inRegA;
    logic [WIDTH-1:0] inRegB;
    logic [RW-1:0]    calcRes;
`ifdef PIPE_ADDSUB_SAT_EN
    logic             calcSat;
`endif
    stage_t           stageIn;
    stage_t [LATENCY:0] chain;
    stage_t           tail;

    assign tail     = chain[LATENCY];
    assign en       = !(tail.valid && !outReady);
    assign inReady  = en && !rst;
    assign outValid = tail.valid && !rst;
    assign resOut   = tail.res;
`ifdef PIPE_ADDSUB_SAT_EN
    assign satOut   = tail.sat;
`endif

    // Operand capture: the mode travels with its operands into the compute stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            inRegValid <= 1'b0;
            inRegMode  <= MODE_SUB;
            inRegA     <= '0;
            inRegB     <= '0;
        end else if (en) begin
            inRegValid <= inValid;
            inRegMode  <= modeIn;
            inRegA     <= aIn;
            inRegB     <= bIn;
        end
    end

    addsub_calc #(
        .WIDTH(WIDTH)
    ) calc (
        .mode(inRegMode),
        .a   (inRegA),
        .b   (inRegB),
        .res (calcRes)
`ifdef PIPE_ADDSUB_SAT_EN
        ,
        .sat (calcSat)
`endif
    );

    always_comb begin
        stageIn       = '0;
        stageIn.valid = inRegValid;
        stageIn.res   = calcRes;
`ifdef PIPE_ADDSUB_SAT_EN
        stageIn.sat   = calcSat;
`endif
    end

    assign chain[0] = stageIn;

    // Stage 1 registers the computed result; later stages are pure delay, all gated by en.
    for (genvar i = 0; i < LATENCY; i++) begin : gStage
        stage_t q;

        always_ff @(posedge clk) begin
            if (rst) begin
                q <= '0;
            end else if (en) begin
                q <= chain[i];
            end
        end

        assign chain[i+1] = q;
    end

endmodule

// File: tb/tb_pipe_addsub.sv
// Self-checking bench for pipe_addsub: directed test-plan steps plus random traffic against a queue model.
// Honours PIPE_ADDSUB_SAT_EN the same way as the design.
module tb_pipe_addsub;
    import pipe_addsub_pkg::*;

    localparam int W  = 4;
    localparam int L  = 3;
    localparam int W8 = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         inValid;
    logic         inReady;
    logic [1:0]   modeIn;
    logic [W-1:0] aIn;
    logic [W-1:0] bIn;
    logic         outValid;
    logic         outReady;
    logic [W:0]   resOut;

    logic          inValid8;
    logic          inReady8;
    logic [1:0]    modeIn8;
    logic [W8-1:0] aIn8;
    logic [W8-1:0] bIn8;
    logic          outValid8;
    logic [W8:0]   resOut8;
`ifdef PIPE_ADDSUB_SAT_EN
    logic          satOut;
    logic          satOut8;
`endif

    always #5 clk = ~clk;

    pipe_addsub #(.WIDTH(W), .LATENCY(L)) dut (
        .clk(clk), .rst(rst), .inValid(inValid), .inReady(inReady), .modeIn(modeIn),
        .aIn(aIn), .bIn(bIn), .outValid(outValid), .outReady(outReady), .resOut(resOut)
`ifdef PIPE_ADDSUB_SAT_EN
        , .satOut(satOut)
`endif
    );

    pipe_addsub #(.WIDTH(W8), .LATENCY(1)) dut8 (
        .clk(clk), .rst(rst), .inValid(inValid8), .inReady(inReady8), .modeIn(modeIn8),
        .aIn(aIn8), .bIn(bIn8), .outValid(outValid8), .outReady(1'b1), .resOut(resOut8)
`ifdef PIPE_ADDSUB_SAT_EN
        , .satOut(satOut8)
`endif
    );

    typedef struct {
        logic [W:0] res;
        logic       sat;
        int         moves;
    } beat_t;

    beat_t pending[$];
    int    nVec = 0;
    int    nMiss = 0;
    bit    justReset = 1'b1;

    function automatic int refExact(input logic [1:0] m, input int a, input int b);
        case (m)
            MODE_SUB:  return a - b;
            MODE_ADD:  return a + b;
            MODE_RSUB: return b - a;
            default:   return (a > b) ? a - b : b - a;
        endcase
    endfunction

    function automatic bit modelValid();
        return (pending.size() > 0) && (pending[0].moves >= L);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nVec++;
        assert (obs === exp) else begin
            nMiss++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        bit mv;
        mv = modelValid();
        check("outValid", 32'(outValid), rst ? 32'd0 : 32'(mv));
        check("inReady", 32'(inReady), rst ? 32'd0 : 32'(!(mv && !outReady)));
        if (!rst && mv) begin
            check("resOut", 32'(resOut), 32'(pending[0].res));
`ifdef PIPE_ADDSUB_SAT_EN
            check("satOut", 32'(satOut), 32'(pending[0].sat));
`endif
        end
        if (!rst && justReset) begin
            check("resOutAfterReset", 32'(resOut), 32'd0);
`ifdef PIPE_ADDSUB_SAT_EN
            check("satOutAfterReset", 32'(satOut), 32'd0);
`endif
        end
    endtask

    // One clock cycle: drive at the falling edge, check, advance the model across the rising edge.
    task automatic applyStimulus(input logic v, input logic [1:0] m, input int a, input int b,
                                 input logic ordy);
        bit    mv;
        bit    moving;
        int    ex;
        beat_t nb;
        inValid  = v;
        modeIn   = m;
        aIn      = a[W-1:0];
        bIn      = b[W-1:0];
        outReady = ordy;
        #1;
        checkOutput();
        mv     = modelValid();
        moving = !(mv && !ordy);
        if (rst) begin
            pending.delete();
            justReset = 1'b1;
        end else begin
            justReset = 1'b0;
            if (mv && ordy) void'(pending.pop_front());
            if (moving) begin
                foreach (pending[i]) pending[i].moves = pending[i].moves + 1;
                if (v) begin
                    ex     = refExact(m, a, b);
                    nb.sat = 1'b0;
`ifdef PIPE_ADDSUB_SAT_EN
                    if (ex > (1 << W) - 1) begin
                        ex     = (1 << W) - 1;
                        nb.sat = 1'b1;
                    end
`endif
                    nb.res   = ex[W:0];
                    nb.moves = 0;
                    pending.push_back(nb);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, MODE_SUB, 0, 0, 1'b1);
    endtask

    initial begin
        rst      = 1'b1;
        inValid  = 1'b0;
        modeIn   = MODE_SUB;
        aIn      = '0;
        bIn      = '0;
        outReady = 1'b1;
        inValid8 = 1'b0;
        modeIn8  = MODE_SUB;
        aIn8     = '0;
        bIn8     = '0;
        @(negedge clk);
        applyStimulus(1'b1, MODE_SUB, 1, 1, 1'b1);
        rst = 1'b0;

        applyStimulus(1'b1, MODE_SUB, 10, 6, 1'b1);
        applyStimulus(1'b1, MODE_SUB, 5, 8, 1'b1);
        applyStimulus(1'b1, MODE_SUB, 3, 3, 1'b1);
        idle(5);

        applyStimulus(1'b1, MODE_RSUB, 5, 8, 1'b1);
        applyStimulus(1'b1, MODE_ABS, 5, 8, 1'b1);
        applyStimulus(1'b1, MODE_ADD, 5, 8, 1'b1);
        applyStimulus(1'b1, MODE_SUB, 5, 8, 1'b1);
        idle(5);

        applyStimulus(1'b1, MODE_ADD, 15, 15, 1'b1);
        applyStimulus(1'b1, MODE_ADD, 1, 2, 1'b1);
        idle(5);

        // Four beats, then a two-cycle stall while the first result is showing.
        applyStimulus(1'b1, MODE_SUB, 9, 1, 1'b1);
        applyStimulus(1'b1, MODE_ADD, 2, 3, 1'b1);
        applyStimulus(1'b1, MODE_RSUB, 4, 12, 1'b1);
        applyStimulus(1'b1, MODE_ABS, 1, 14, 1'b1);
        applyStimulus(1'b0, MODE_SUB, 0, 0, 1'b0);
        applyStimulus(1'b0, MODE_SUB, 0, 0, 1'b0);
        idle(6);

        // Reset with three beats in flight; nothing stale may surface afterwards.
        applyStimulus(1'b1, MODE_ADD, 6, 6, 1'b1);
        applyStimulus(1'b1, MODE_SUB, 2, 9, 1'b1);
        applyStimulus(1'b1, MODE_ABS, 11, 4, 1'b1);
        rst = 1'b1;
        applyStimulus(1'b1, MODE_ADD, 3, 3, 1'b1);
        rst = 1'b0;
        idle(5);
        applyStimulus(1'b1, MODE_SUB, 7, 2, 1'b1);
        idle(5);

        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                          int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                          1'($urandom_range(0, 3) != 0));
        end
        idle(L + 3);

        // Wide, single-stage instance.
        inValid8 = 1'b1; modeIn8 = MODE_SUB; aIn8 = 8'd0; bIn8 = 8'd255;
        #1;
        check("w8IdleValid", 32'(outValid8), 32'd0);
        check("w8Ready", 32'(inReady8), 32'd1);
        @(negedge clk);
        inValid8 = 1'b1; modeIn8 = MODE_ADD; aIn8 = 8'd255; bIn8 = 8'd255;
        #1;
        check("w8NotYetValid", 32'(outValid8), 32'd0);
        @(negedge clk);
        inValid8 = 1'b0;
        #1;
        check("w8SubValid", 32'(outValid8), 32'd1);
        check("w8SubRes", 32'(resOut8), 32'h101);
        @(negedge clk);
        #1;
        check("w8AddValid", 32'(outValid8), 32'd1);
`ifdef PIPE_ADDSUB_SAT_EN
        check("w8AddRes", 32'(resOut8), 32'h0FF);
        check("w8AddSat", 32'(satOut8), 32'd1);
`else
        check("w8AddRes", 32'(resOut8), 32'h1FE);
`endif
        @(negedge clk);
        #1;
        check("w8Drained", 32'(outValid8), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
        $finish;
    end

endmodule
